// File: rtl/sprite_overlay_scaler.sv
// Sprite overlay stage: places an IMG_W x IMG_H ROM image at a runtime
// position with integer upscaling, fills everything else with BG_COLOR, and
// delays the sync bundle so that it stays aligned with the pixel colour.
// ROM addresses are built incrementally (row base plus column offset), so the
// address path needs no multiplier.
module sprite_overlay_scaler #(
  parameter int          IMG_W    = 200,
  parameter int          IMG_H    = 150,
  parameter int          ADDR_W   = 16,
  parameter int          ROM_LAT  = 1,
  parameter int          SCALE_W  = 3,
  parameter logic [23:0] BG_COLOR = 24'h101040
) (
  input  logic               hdmi_clk,
  input  logic               rst,
  input  logic [2:0]         in_hve,
  input  logic [12:0]        in_x,
  input  logic [12:0]        in_y,
  input  logic [12:0]        pos_x,
  input  logic [12:0]        pos_y,
  input  logic [SCALE_W-1:0] scale,
  input  logic               enable,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [23:0]        rom_data,
  output logic [2:0]         out_hve,
  output logic [23:0]        out_rgb
);

  localparam logic [SCALE_W-1:0] SCALE_ONE = SCALE_W'(1);
  localparam logic [ADDR_W-1:0]  ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]  ROW_STEP  = ADDR_W'(IMG_W);

  // Frame-stable copies of the placement controls
  logic [12:0]        sx_q, sy_q;
  logic [SCALE_W-1:0] s_q;
  logic               en_q;
  logic               armed_q;

  // Address generation state
  logic [ADDR_W-1:0]  row_base_q, col_addr_q;
  logic [SCALE_W-1:0] row_rep_q, col_rep_q;
  logic               line_hit_q;
  logic               de_q;

  // Next-state values
  logic [ADDR_W-1:0]  row_base_n, col_addr_n, addr_n;
  logic [SCALE_W-1:0] row_rep_n, col_rep_n;
  logic               line_hit_n;

  // Values as seen this cycle (frame start overrides the registered copies)
  logic               de, frame_start;
  logic [SCALE_W-1:0] scale_fix;
  logic [12:0]        sx_e, sy_e;
  logic [SCALE_W-1:0] s_e, s_m1;
  logic               en_e, armed_e;
  logic [ADDR_W-1:0]  row_base_c, col_addr_c;
  logic [SCALE_W-1:0] row_rep_c, col_rep_c;
  logic               line_hit_c;
  logic [13:0]        span_x, span_y, x_end, y_end;
  logic               xr, yr, hit, line_end;

  // Pipeline towards the output register
  logic [2:0]         hve_pipe [ROM_LAT];
  logic [ROM_LAT-1:0] sel_pipe;

  assign de          = in_hve[2];
  assign frame_start = de && (in_x == 13'd0) && (in_y == 13'd0);
  assign scale_fix   = (scale == '0) ? SCALE_ONE : scale;
  assign line_end    = de_q && !de;

  // Frame start makes the freshly captured controls and cleared counters
  // visible on the very same cycle, so a hit at (0,0) already uses them.
  always_comb begin
    sx_e       = sx_q;
    sy_e       = sy_q;
    s_e        = s_q;
    en_e       = en_q;
    armed_e    = armed_q;
    row_base_c = row_base_q;
    col_addr_c = col_addr_q;
    row_rep_c  = row_rep_q;
    col_rep_c  = col_rep_q;
    line_hit_c = line_hit_q;
    if (frame_start) begin
      sx_e       = pos_x;
      sy_e       = pos_y;
      s_e        = scale_fix;
      en_e       = enable;
      armed_e    = 1'b1;
      row_base_c = '0;
      col_addr_c = '0;
      row_rep_c  = '0;
      col_rep_c  = '0;
      line_hit_c = 1'b0;
    end
  end

  // Image window in 14 bits so a far-right/bottom position cannot wrap.
  assign s_m1   = s_e - SCALE_ONE;
  assign span_x = 14'(IMG_W) * {{(14-SCALE_W){1'b0}}, s_e};
  assign span_y = 14'(IMG_H) * {{(14-SCALE_W){1'b0}}, s_e};
  assign x_end  = {1'b0, sx_e} + span_x;
  assign y_end  = {1'b0, sy_e} + span_y;
  assign xr     = ({1'b0, in_x} >= {1'b0, sx_e}) && ({1'b0, in_x} < x_end);
  assign yr     = ({1'b0, in_y} >= {1'b0, sy_e}) && ({1'b0, in_y} < y_end);
  assign hit    = de && xr && yr && en_e && armed_e;

  // Column stepping on hits, row stepping at the end of a line that drew pixels.
  always_comb begin
    addr_n     = '0;
    row_base_n = row_base_c;
    col_addr_n = col_addr_c;
    row_rep_n  = row_rep_c;
    col_rep_n  = col_rep_c;
    line_hit_n = line_hit_c;
    if (hit) begin
      addr_n     = row_base_c + col_addr_c;
      line_hit_n = 1'b1;
      if (col_rep_c == s_m1) begin
        col_rep_n  = '0;
        col_addr_n = col_addr_c + ADDR_ONE;
      end else begin
        col_rep_n = col_rep_c + SCALE_ONE;
      end
    end else if (line_end && line_hit_c) begin
      col_addr_n = '0;
      col_rep_n  = '0;
      line_hit_n = 1'b0;
      if (row_rep_c == s_m1) begin
        row_rep_n  = '0;
        row_base_n = row_base_c + ROW_STEP;
      end else begin
        row_rep_n = row_rep_c + SCALE_ONE;
      end
    end
  end

  // Control registers: shadow capture, frame arming and address counters.
  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      sx_q       <= '0;
      sy_q       <= '0;
      s_q        <= SCALE_ONE;
      en_q       <= 1'b0;
      armed_q    <= 1'b0;
      row_base_q <= '0;
      col_addr_q <= '0;
      row_rep_q  <= '0;
      col_rep_q  <= '0;
      line_hit_q <= 1'b0;
      de_q       <= 1'b0;
      rom_addr   <= '0;
    end else begin
      sx_q       <= sx_e;
      sy_q       <= sy_e;
      s_q        <= s_e;
      en_q       <= en_e;
      armed_q    <= armed_e;
      row_base_q <= row_base_n;
      col_addr_q <= col_addr_n;
      row_rep_q  <= row_rep_n;
      col_rep_q  <= col_rep_n;
      line_hit_q <= line_hit_n;
      de_q       <= de;
      rom_addr   <= addr_n;
    end
  end

  // Delay line for sync and pixel-select, then the registered colour mux.
  // ROM_LAT stages plus the output register give ROM_LAT+1 total latency.
  always_ff @(posedge hdmi_clk) begin
    if (rst) begin
      for (int i = 0; i < ROM_LAT; i++) hve_pipe[i] <= '0;
      sel_pipe <= '0;
      out_hve  <= '0;
      out_rgb  <= '0;
    end else begin
      hve_pipe[0] <= in_hve;
      sel_pipe[0] <= hit;
      for (int i = 1; i < ROM_LAT; i++) begin
        hve_pipe[i] <= hve_pipe[i-1];
        sel_pipe[i] <= sel_pipe[i-1];
      end
      out_hve <= hve_pipe[ROM_LAT-1];
      if (!hve_pipe[ROM_LAT-1][2]) out_rgb <= '0;
      else if (sel_pipe[ROM_LAT-1]) out_rgb <= rom_data;
      else out_rgb <= BG_COLOR;
    end
  end

endmodule

// File: tb/tb_sprite_overlay_scaler.sv
// Directed bench for sprite_overlay_scaler on a reduced 40x30 raster with an
// 8x6 image. Two instances run side by side: ROM_LAT=1 and ROM_LAT=3.
module tb_sprite_overlay_scaler;
  localparam int AW = 40, AH = 30, HT = 46, VT = 33;
  localparam logic [23:0] BG = 24'h101040;

  logic        hdmi_clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  in_hve = '0;
  logic [12:0] in_x = '0, in_y = '0, pos_x = '0, pos_y = '0;
  logic [2:0]  scale = 3'd1;
  logic        enable = 1'b0;
  logic [15:0] rom_addr1, rom_addr3;
  logic [23:0] rom_data1, rom_data3, r3a, r3b;
  logic [2:0]  out_hve1, out_hve3;
  logic [23:0] out_rgb1, out_rgb3;

  always #5 hdmi_clk = ~hdmi_clk;

  sprite_overlay_scaler #(.IMG_W(8), .IMG_H(6), .ADDR_W(16), .ROM_LAT(1),
    .SCALE_W(3), .BG_COLOR(24'h101040)) dut1 (
    .hdmi_clk(hdmi_clk), .rst(rst), .in_hve(in_hve), .in_x(in_x), .in_y(in_y),
    .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .enable(enable),
    .rom_addr(rom_addr1), .rom_data(rom_data1), .out_hve(out_hve1), .out_rgb(out_rgb1));

  sprite_overlay_scaler #(.IMG_W(8), .IMG_H(6), .ADDR_W(16), .ROM_LAT(3),
    .SCALE_W(3), .BG_COLOR(24'h101040)) dut3 (
    .hdmi_clk(hdmi_clk), .rst(rst), .in_hve(in_hve), .in_x(in_x), .in_y(in_y),
    .pos_x(pos_x), .pos_y(pos_y), .scale(scale), .enable(enable),
    .rom_addr(rom_addr3), .rom_data(rom_data3), .out_hve(out_hve3), .out_rgb(out_rgb3));

  // ROM contents: a tag byte plus the address, distinct from BG and blanking
  function automatic logic [23:0] rom_f(input logic [15:0] a);
    return {8'hA5, a};
  endfunction

  // ROM_LAT=1: data follows the address register directly
  assign rom_data1 = rom_f(rom_addr1);
  // ROM_LAT=3: two further register stages behind the address register
  always @(posedge hdmi_clk) begin
    r3a <= rom_f(rom_addr3);
    r3b <= r3a;
  end
  assign rom_data3 = r3b;

  int n_tests = 0, n_fail = 0;
  int n = 16;
  int skip = 0, rst_watch = 0;
  int align_err1 = 0, align_err3 = 0, blank_err = 0, rst_err = 0;
  logic [2:0]  h_hve [16];
  logic [12:0] h_x [16];
  logic [12:0] h_y [16];
  logic [23:0] cap1 [AH][AW];
  logic [23:0] cap3 [AH][AW];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One pixel clock: drive after the edge, sample at the falling edge and
  // match outputs with the inputs driven LAT steps earlier.
  task automatic step(input logic [2:0] hve, input logic [12:0] x, input logic [12:0] y);
    int i1, i3;
    @(posedge hdmi_clk);
    #1;
    in_hve = hve;
    in_x   = x;
    in_y   = y;
    h_hve[n & 15] = hve;
    h_x[n & 15]   = x;
    h_y[n & 15]   = y;
    @(negedge hdmi_clk);
    i1 = (n - 2) & 15;
    i3 = (n - 4) & 15;
    if (rst_watch > 0) begin
      if (rom_addr1 !== 16'd0 || out_hve1 !== 3'd0 || out_rgb1 !== 24'd0 ||
          out_hve3 !== 3'd0 || out_rgb3 !== 24'd0) rst_err++;
      rst_watch--;
    end
    if (skip > 0) skip--;
    else begin
      if (out_hve1 !== h_hve[i1]) align_err1++;
      if (out_hve3 !== h_hve[i3]) align_err3++;
      if (!out_hve1[2] && out_rgb1 !== 24'd0) blank_err++;
      if (!out_hve3[2] && out_rgb3 !== 24'd0) blank_err++;
    end
    if (h_hve[i1][2]) cap1[int'(h_y[i1])][int'(h_x[i1])] = out_rgb1;
    if (h_hve[i3][2]) cap3[int'(h_y[i3])][int'(h_x[i3])] = out_rgb3;
    n++;
  endtask

  // One full frame; optionally move pos_x at a line start or pulse rst
  // for three cycles in the middle of a line.
  task automatic run_frame(input int chg_y, input logic [12:0] chg_px, input int rst_y);
    logic de, hs, vs;
    for (int y = 0; y < VT; y++) begin
      for (int x = 0; x < HT; x++) begin
        if (y == chg_y && x == 0) pos_x = chg_px;
        if (y == rst_y && x == 2) begin
          rst = 1'b1;
          rst_watch = 3;
          skip = 12;
        end
        if (y == rst_y && x == 5) rst = 1'b0;
        de = (x < AW) && (y < AH);
        hs = (x >= 42) && (x < 44);
        vs = (y == 31);
        step({de, vs, hs}, 13'(x), 13'(y));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      h_hve[i] = '0;
      h_x[i] = '0;
      h_y[i] = '0;
    end
    rst = 1'b1;
    repeat (3) step(3'd0, 13'd0, 13'd0);
    check("rst_rom_addr", 32'(rom_addr1), 32'd0);
    check("rst_out_hve1", 32'(out_hve1), 32'd0);
    check("rst_out_rgb1", 32'(out_rgb1), 32'd0);
    check("rst_out_hve3", 32'(out_hve3), 32'd0);
    check("rst_out_rgb3", 32'(out_rgb3), 32'd0);
    rst = 1'b0;

    // scale 1 at (10,5): image covers x 10..17, y 5..10
    pos_x = 13'd10; pos_y = 13'd5; scale = 3'd1; enable = 1'b1;
    run_frame(-1, 13'd0, -1);
    check("s1_first",     32'(cap1[5][10]),  32'(rom_f(16'd0)));
    check("s1_last",      32'(cap1[10][17]), 32'(rom_f(16'd47)));
    check("s1_row1",      32'(cap1[6][10]),  32'(rom_f(16'd8)));
    check("s1_left_bg",   32'(cap1[5][9]),   32'(BG));
    check("s1_right_bg",  32'(cap1[5][18]),  32'(BG));
    check("s1_below_bg",  32'(cap1[11][10]), 32'(BG));
    check("lat4_first",   32'(cap3[5][10]),  32'(rom_f(16'd0)));
    check("lat4_last",    32'(cap3[10][17]), 32'(rom_f(16'd47)));

    // scale 2 at origin: frame start and first hit coincide
    pos_x = 13'd0; pos_y = 13'd0; scale = 3'd2;
    run_frame(-1, 13'd0, -1);
    check("s2_00", 32'(cap1[0][0]),   32'(rom_f(16'd0)));
    check("s2_10", 32'(cap1[0][1]),   32'(rom_f(16'd0)));
    check("s2_01", 32'(cap1[1][0]),   32'(rom_f(16'd0)));
    check("s2_11", 32'(cap1[1][1]),   32'(rom_f(16'd0)));
    check("s2_20", 32'(cap1[0][2]),   32'(rom_f(16'd1)));
    check("s2_02", 32'(cap1[2][0]),   32'(rom_f(16'd8)));
    check("s2_end", 32'(cap1[11][15]), 32'(rom_f(16'd47)));
    check("s2_xbg", 32'(cap1[0][16]),  32'(BG));
    check("s2_ybg", 32'(cap1[12][0]),  32'(BG));
    check("s2_lat4", 32'(cap3[2][2]),  32'(rom_f(16'd9)));

    // clipped at bottom-right corner
    pos_x = 13'd36; pos_y = 13'd27; scale = 3'd1;
    run_frame(-1, 13'd0, -1);
    check("clip_first",  32'(cap1[27][36]), 32'(rom_f(16'd0)));
    check("clip_edge",   32'(cap1[27][39]), 32'(rom_f(16'd3)));
    check("clip_row1",   32'(cap1[28][36]), 32'(rom_f(16'd8)));
    check("clip_corner", 32'(cap1[29][39]), 32'(rom_f(16'd19)));
    check("clip_bg",     32'(cap1[27][35]), 32'(BG));

    // pos_x moves mid-frame: only the next frame follows it
    pos_x = 13'd10; pos_y = 13'd5;
    run_frame(8, 13'd20, -1);
    check("mid_old_pos", 32'(cap1[8][10]), 32'(rom_f(16'd24)));
    check("mid_new_bg",  32'(cap1[8][20]), 32'(BG));
    run_frame(-1, 13'd0, -1);
    check("next_new_pos", 32'(cap1[5][20]), 32'(rom_f(16'd0)));
    check("next_old_bg",  32'(cap1[5][10]), 32'(BG));

    // scale 0 behaves as scale 1
    pos_x = 13'd4; pos_y = 13'd4; scale = 3'd0;
    run_frame(-1, 13'd0, -1);
    check("s0_first", 32'(cap1[4][4]), 32'(rom_f(16'd0)));
    check("s0_col1",  32'(cap1[4][5]), 32'(rom_f(16'd1)));
    check("s0_row1",  32'(cap1[5][4]), 32'(rom_f(16'd8)));

    // enable low: background only
    scale = 3'd1; enable = 1'b0;
    run_frame(-1, 13'd0, -1);
    check("dis_bg1", 32'(cap1[4][4]), 32'(BG));
    check("dis_bg3", 32'(cap3[5][6]), 32'(BG));

    // reset pulse at line 12 of a scale-2 frame
    pos_x = 13'd10; pos_y = 13'd5; scale = 3'd2; enable = 1'b1;
    run_frame(-1, 13'd0, 12);
    check("pre_rst_pix",  32'(cap1[5][12]),  32'(rom_f(16'd1)));
    check("rst_mid_zero", 32'(rst_err),      32'd0);
    check("post_rst_bg1", 32'(cap1[14][10]), 32'(BG));
    check("post_rst_bg2", 32'(cap1[16][25]), 32'(BG));
    check("post_rst_bg3", 32'(cap3[14][10]), 32'(BG));
    run_frame(-1, 13'd0, -1);
    check("rec_first", 32'(cap1[5][10]),  32'(rom_f(16'd0)));
    check("rec_mid",   32'(cap1[7][12]),  32'(rom_f(16'd9)));
    check("rec_last",  32'(cap1[16][25]), 32'(rom_f(16'd47)));
    check("rec_lat4",  32'(cap3[16][25]), 32'(rom_f(16'd47)));

    check("hve_align_lat2", 32'(align_err1), 32'd0);
    check("hve_align_lat4", 32'(align_err3), 32'd0);
    check("blank_zero",     32'(blank_err),  32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
